// File: rtl/i2c_txn_arbiter_if.sv
// rtl/i2c_txn_arbiter_if.sv - client request/response and engine launch/done bundle for i2c_txn_arbiter
// Purpose: groups every non-clock, non-reset signal of the arbiter.
// Signals:
//   req_valid/req_rw/req_dev/req_reg/req_wdata  client -> arbiter request fields
//   req_ready                                   arbiter -> client one-hot accept pulse
//   rsp_valid/rsp_rdata/rsp_nack                arbiter -> owning client completion
//   eng_start/eng_rw/eng_dev/eng_reg/eng_wdata  arbiter -> engine launch and latched fields
//   eng_busy/eng_done/eng_nack/eng_rdata        engine -> arbiter status and result
//   arb_busy                                    arbiter not idle
// Modports: master = arbiter side, slave = clients plus engine side.
interface i2c_txn_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_rw;
  logic [7*NREQ-1:0] req_dev;
  logic [8*NREQ-1:0] req_reg;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_nack;
  logic              eng_start;
  logic              eng_rw;
  logic [6:0]        eng_dev;
  logic [7:0]        eng_reg;
  logic [7:0]        eng_wdata;
  logic              eng_busy;
  logic              eng_done;
  logic              eng_nack;
  logic [7:0]        eng_rdata;
  logic              arb_busy;

  modport master (
    input  req_valid, req_rw, req_dev, req_reg, req_wdata,
    input  eng_busy, eng_done, eng_nack, eng_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_nack,
    output eng_start, eng_rw, eng_dev, eng_reg, eng_wdata,
    output arb_busy
  );

  modport slave (
    output req_valid, req_rw, req_dev, req_reg, req_wdata,
    output eng_busy, eng_done, eng_nack, eng_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_nack,
    input  eng_start, eng_rw, eng_dev, eng_reg, eng_wdata,
    input  arb_busy
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin arbiter sharing one byte-level I2C master engine
// Purpose: grants one register transaction per turn to NREQ clients, launches it
//   on the engine, waits for eng_done under a watchdog, and returns read data and
//   NACK status to the owning client. All outputs are registered.
// Ports:
//   clk   system clock, rising edge
//   nrst  asynchronous active-low reset
//   bus   i2c_txn_arbiter_if.master (client req/rsp, engine launch/done, arb_busy)
// Config: I2C_ARB_RETRY_EN - when defined, a NACKed attempt is re-issued up to
//   MAX_RETRY times before the NACK is reported; timeouts are never retried.
module i2c_txn_arbiter #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY   = 2
) (
  input  logic              clk,
  input  logic              nrst,
  i2c_txn_arbiter_if.master bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;

  if (NREQ < 1 || NREQ > 8 || TIMEOUT_CYC < 2 || MAX_RETRY < 0) begin : g_bad_cfg
    $error("i2c_txn_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  state_e state_q, state_d;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, grant_idx;
  logic             grant_found;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             wd_expired, finish, do_retry;
  logic             sel_rw;
  logic [6:0]       sel_dev;
  logic [7:0]       sel_reg, sel_wdata;

  logic [NREQ-1:0]  req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             rsp_nack_q, rsp_nack_d;
  logic             eng_start_q, eng_start_d, eng_rw_q, eng_rw_d;
  logic [6:0]       eng_dev_q, eng_dev_d;
  logic [7:0]       eng_reg_q, eng_reg_d, eng_wdata_q, eng_wdata_d;
  logic             arb_busy_q, arb_busy_d;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin : grant_search
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NREQ;
      if (!grant_found && bus.req_valid[PTR_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    sel_rw    = 1'b0;
    sel_dev   = '0;
    sel_reg   = '0;
    sel_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (PTR_W'(k) == grant_idx) begin
        sel_rw    = bus.req_rw[k];
        sel_dev   = bus.req_dev[7*k +: 7];
        sel_reg   = bus.req_reg[8*k +: 8];
        sel_wdata = bus.req_wdata[8*k +: 8];
      end
    end
  end

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYC - 1));

`ifdef I2C_ARB_RETRY_EN
  localparam int RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RC_W-1:0] retry_cnt_q, retry_cnt_d;

  assign do_retry = (state_q == S_WAIT) && bus.eng_done && bus.eng_nack &&
                    (int'(retry_cnt_q) < MAX_RETRY);

  always_comb begin
    retry_cnt_d = retry_cnt_q;
    if (state_q == S_IDLE && grant_found) retry_cnt_d = '0;
    else if (do_retry)                    retry_cnt_d = retry_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) retry_cnt_q <= '0;
    else       retry_cnt_q <= retry_cnt_d;
  end
`else
  assign do_retry = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // eng_done takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_found) state_d = S_ISSUE;
      S_ISSUE: if (!bus.eng_busy) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.eng_done)    state_d = do_retry ? S_ISSUE : S_RESP;
        else if (wd_expired) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign finish = (state_q == S_WAIT) && (state_d == S_RESP);

  always_comb begin
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_nack_d  = 1'b0;
    eng_start_d = 1'b0;
    eng_rw_d    = eng_rw_q;
    eng_dev_d   = eng_dev_q;
    eng_reg_d   = eng_reg_q;
    eng_wdata_d = eng_wdata_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    wd_d        = wd_q;
    arb_busy_d  = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          for (int k = 0; k < NREQ; k++) req_ready_d[k] = (PTR_W'(k) == grant_idx);
          eng_rw_d    = sel_rw;
          eng_dev_d   = sel_dev;
          eng_reg_d   = sel_reg;
          eng_wdata_d = sel_wdata;
          owner_d     = grant_idx;
        end
      end
      S_ISSUE: begin
        if (!bus.eng_busy) begin
          eng_start_d = 1'b1;
          wd_d        = '0;
        end
      end
      S_WAIT: begin
        if (wd_q != '1) wd_d = wd_q + 1'b1;
        if (finish) begin
          for (int k = 0; k < NREQ; k++) rsp_valid_d[k] = (PTR_W'(k) == owner_q);
          rsp_nack_d = bus.eng_done ? bus.eng_nack : 1'b1;
          if (bus.eng_done && !bus.eng_nack && eng_rw_q) rsp_rdata_d = bus.eng_rdata;
        end
      end
      S_RESP: rr_ptr_d = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_nack_q  <= 1'b0;
      eng_start_q <= 1'b0;
      eng_rw_q    <= 1'b0;
      eng_dev_q   <= '0;
      eng_reg_q   <= '0;
      eng_wdata_q <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      wd_q        <= '0;
      arb_busy_q  <= 1'b0;
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_nack_q  <= rsp_nack_d;
      eng_start_q <= eng_start_d;
      eng_rw_q    <= eng_rw_d;
      eng_dev_q   <= eng_dev_d;
      eng_reg_q   <= eng_reg_d;
      eng_wdata_q <= eng_wdata_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      wd_q        <= wd_d;
      arb_busy_q  <= arb_busy_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_nack  = rsp_nack_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_rw    = eng_rw_q;
  assign bus.eng_dev   = eng_dev_q;
  assign bus.eng_reg   = eng_reg_q;
  assign bus.eng_wdata = eng_wdata_q;
  assign bus.arb_busy  = arb_busy_q;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - randomized self-checking bench for i2c_txn_arbiter
module tb_i2c_txn_arbiter;
  localparam int NREQ = 2;
  localparam int TMO  = 16;
  localparam int MAXR = 2;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Client-side view of each requester's fields, and the reference round-robin pointer.
  logic       cl_rw  [NREQ];
  logic [6:0] cl_dev [NREQ];
  logic [7:0] cl_reg [NREQ];
  logic [7:0] cl_wd  [NREQ];
  int         rr_ptr = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_fields();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_rw[i]          = cl_rw[i];
      bus.req_dev[7*i +: 7]  = cl_dev[i];
      bus.req_reg[8*i +: 8]  = cl_reg[i];
      bus.req_wdata[8*i +: 8] = cl_wd[i];
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] valid, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (valid[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // One full transaction. nacks = number of leading attempts the slave NACKs;
  // tmo = engine never finishes; busy_n = cycles eng_busy stays high after accept.
  task automatic run_txn(input string name, input logic [NREQ-1:0] mask, input bit rnd,
                         input int nacks, input bit tmo, input int busy_n, input int frd);
    int g, starts, c_start, c_rsp, lat, extra, fields_bad, early, exp_starts;
    bit got, pending, exp_nack;
    logic [7:0] rd_last, exp_rd;
    starts = 0; c_start = -1; c_rsp = -1; lat = 0; extra = 0; fields_bad = 0; early = 0;
    pending = 0; rd_last = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (rnd && mask[i] && !bus.req_valid[i]) begin
        cl_rw[i]  = 1'($urandom);
        cl_dev[i] = 7'($urandom);
        cl_reg[i] = 8'($urandom);
        cl_wd[i]  = 8'($urandom);
      end
    end
    drive_fields();
    bus.req_valid = bus.req_valid | mask;
    g = pick(bus.req_valid, rr_ptr);
    bus.eng_busy = (busy_n > 0);

    got = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.rsp_valid != '0) extra++;
      if (bus.req_ready != '0) begin got = 1; break; end
    end
    check_eq({name, "_ready_seen"}, 64'(got), 64'd1);
    if (!got) return;
    check_eq({name, "_grant"}, 64'(bus.req_ready), 64'(1 << g));
    bus.req_valid[g] = 1'b0;

    for (int i = 0; i < busy_n; i++) begin
      tick();
      if (bus.eng_start) early++;
      if (bus.req_ready != '0) extra++;
    end
    bus.eng_busy = 1'b0;

    got = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      bus.eng_done  = 1'b0;
      bus.eng_nack  = 1'($urandom);
      bus.eng_rdata = 8'($urandom);
      if (bus.req_ready != '0) extra++;
      if (starts > 0 && {bus.eng_rw, bus.eng_dev, bus.eng_reg, bus.eng_wdata} !==
                        {cl_rw[g], cl_dev[g], cl_reg[g], cl_wd[g]}) fields_bad++;
      if (bus.rsp_valid != '0) begin
        got = 1; c_rsp = c;
        check_eq({name, "_rsp_owner"}, 64'(bus.rsp_valid), 64'(1 << g));
        check_eq({name, "_busy_in_resp"}, 64'(bus.arb_busy), 64'd1);
        break;
      end
      if (bus.eng_start) begin
        if (starts == 0) c_start = c;
        starts++;
        pending = 1;
        lat = $urandom_range(0, 4);
      end
      if (pending && !tmo) begin
        if (lat == 0) begin
          bus.eng_done = 1'b1;
          bus.eng_nack = (starts <= nacks);
          bus.eng_rdata = (frd >= 0) ? 8'(frd) : 8'($urandom);
          rd_last = bus.eng_rdata;
          pending = 0;
        end else lat--;
      end
    end
    bus.eng_done = 1'b0;
    check_eq({name, "_rsp_seen"}, 64'(got), 64'd1);

`ifdef I2C_ARB_RETRY_EN
    exp_starts = tmo ? 1 : (((nacks > MAXR) ? MAXR : nacks) + 1);
    exp_nack   = tmo || (nacks > MAXR);
`else
    exp_starts = 1;
    exp_nack   = tmo || (nacks > 0);
`endif
    exp_rd = (cl_rw[g] && !exp_nack) ? rd_last : 8'h00;
    if (got) begin
      check_eq({name, "_rsp_nack"}, 64'(bus.rsp_nack), 64'(exp_nack));
      check_eq({name, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(exp_rd));
    end
    check_eq({name, "_start_count"}, 64'(starts), 64'(exp_starts));
    check_eq({name, "_start_latency"}, 64'(c_start), 64'd0);
    check_eq({name, "_early_start"}, 64'(early), 64'd0);
    check_eq({name, "_eng_fields"}, 64'(fields_bad), 64'd0);
    check_eq({name, "_stray_ready_rsp"}, 64'(extra), 64'd0);
    if (tmo) check_eq({name, "_timeout_cycles"}, 64'(c_rsp - c_start), 64'(TMO));
    rr_ptr = (g + 1) % NREQ;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctrl"}, 64'({bus.req_ready, bus.rsp_valid, bus.rsp_nack, bus.eng_start,
                                 bus.arb_busy, bus.rsp_rdata}), 64'd0);
    check_eq({tag, "_eng_fields"}, 64'({bus.eng_rw, bus.eng_dev, bus.eng_reg, bus.eng_wdata}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int bad;
    bit got;
    bus.req_valid = '0; bus.req_rw = '0; bus.req_dev = '0; bus.req_reg = '0; bus.req_wdata = '0;
    bus.eng_busy = 1'b0; bus.eng_done = 1'b0; bus.eng_nack = 1'b0; bus.eng_rdata = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      cl_rw[i] = 1'b0; cl_dev[i] = '0; cl_reg[i] = '0; cl_wd[i] = '0;
    end
    repeat (3) tick();
    check_all_zero("reset");
    nrst = 1'b1;
    rr_ptr = 0;
    tick();

    // T1 write from client 0
    cl_rw[0] = 1'b0; cl_dev[0] = 7'h50; cl_reg[0] = 8'h10; cl_wd[0] = 8'hA5;
    run_txn("t1_write", 2'b01, 1'b0, 0, 1'b0, 0, -1);

    // T2 read from client 1
    cl_rw[1] = 1'b1; cl_dev[1] = 7'h68; cl_reg[1] = 8'h75; cl_wd[1] = 8'h00;
    run_txn("t2_read", 2'b10, 1'b0, 0, 1'b0, 0, 8'h71);

    // eng_done while idle must not produce a response
    bad = 0;
    tick(); bus.eng_done = 1'b1; bus.eng_nack = 1'b1;
    tick(); bus.eng_done = 1'b0;
    if (bus.rsp_valid != '0 || bus.arb_busy) bad++;
    repeat (3) begin tick(); if (bus.rsp_valid != '0 || bus.arb_busy || bus.eng_start) bad++; end
    check_eq("idle_done_ignored", 64'(bad), 64'd0);

    // T3 fairness with both clients continuously requesting
    for (int t = 0; t < 4; t++) run_txn("t3_fair", 2'b11, 1'b1, 0, 1'b0, 0, -1);
    bus.req_valid = '0;

    // T6b engine busy delays the launch
    run_txn("t6_busy", 2'b01, 1'b1, 0, 1'b0, 5, -1);

    // T4 watchdog, then a normal transaction
    run_txn("t4_timeout", 2'b10, 1'b1, 0, 1'b1, 0, -1);
    run_txn("t4_after", 2'b01, 1'b1, 0, 1'b0, 0, -1);

    // T5 NACK handling
    cl_rw[1] = 1'b1;
    run_txn("t5_nack2", 2'b10, 1'b0, 2, 1'b0, 0, -1);
    run_txn("t5_nack3", 2'b01, 1'b1, 3, 1'b0, 0, -1);

    // Randomized mix
    for (int t = 0; t < 30; t++)
      run_txn("rand", 2'($urandom_range(1, 3)), 1'b1, $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 3), -1);
    bus.req_valid = '0;

    // T6a reset while waiting on the engine
    tick();
    cl_rw[0] = 1'b1; cl_dev[0] = 7'h2A; cl_reg[0] = 8'h33; cl_wd[0] = 8'h5C;
    drive_fields();
    bus.req_valid = 2'b01;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.req_ready != '0) bus.req_valid = '0;
      if (bus.eng_start) begin got = 1; break; end
    end
    check_eq("rst_wait_started", 64'(got), 64'd1);
    tick();
    bus.eng_busy = 1'b1;
    nrst = 1'b0;
    #1;
    check_all_zero("rst_mid_wait");
    tick();
    nrst = 1'b1;
    rr_ptr = 0;
    bus.eng_busy = 1'b0;
    bad = 0;
    tick(); bus.eng_done = 1'b1; bus.eng_nack = 1'b0;
    tick(); bus.eng_done = 1'b0;
    repeat (4) begin tick(); if (bus.rsp_valid != '0 || bus.eng_start || bus.arb_busy) bad++; end
    check_eq("rst_no_rsp_after", 64'(bad), 64'd0);
    run_txn("post_reset", 2'b11, 1'b1, 0, 1'b0, 0, -1);
    bus.req_valid = '0;

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
